// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default geometry, channel encoding and stereo payload.
package i2s_pkg;

    localparam int unsigned I2S_DATA_SIZE = 24;
    localparam int unsigned I2S_SLOT_BITS = 32;
    localparam int unsigned I2S_CLK_DIV   = 4;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_e;

    typedef struct packed {
        logic [I2S_DATA_SIZE-1:0] left;
        logic [I2S_DATA_SIZE-1:0] right;
    } i2s_stereo_t;

endpackage

// File: rtl/transmitter_i2s_if.sv
// Stereo sample handshake between a sample source and the I2S transmitter.
interface transmitter_i2s_if #(
    parameter int unsigned DATA_SIZE = i2s_pkg::I2S_DATA_SIZE
);
    logic [DATA_SIZE-1:0] sample_left;
    logic [DATA_SIZE-1:0] sample_right;
    logic                 sample_valid;
    logic                 sample_ready;

    modport master (
        output sample_left, sample_right, sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_left, sample_right, sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: toggles sck every CLK_DIV clk cycles; strobes flag the clk
// whose edge produces the next SCK rise or fall.
module i2s_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic sck_o,
    output logic sck_rise_c,
    output logic sck_fall_c
);
    if (CLK_DIV < 1) begin : g_bad_div
        $error("i2s_clk_div: CLK_DIV must be at least 1");
    end

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          term_c;

    always_comb begin
        term_c = (cnt_q == CNT_LAST);
        cnt_d  = term_c ? '0 : cnt_q + CW'(1);
        sck_d  = term_c ? ~sck_q : sck_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o      = sck_q;
    assign sck_rise_c = term_c & ~sck_q;
    assign sck_fall_c = term_c &  sck_q;
endmodule

// File: rtl/transmitter_i2s.sv
// I2S master transmitter: one-pair holding buffer feeding MSB-first serialisers
// with the standard one-bit WS-to-data delay; silence plus underrun when starved.
module transmitter_i2s
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_SIZE = I2S_DATA_SIZE,
    parameter int unsigned SLOT_BITS = I2S_SLOT_BITS,
    parameter int unsigned CLK_DIV   = I2S_CLK_DIV
) (
    input  logic                clk,
    input  logic                rst,
    transmitter_i2s_if.slave    s_if,
    output logic                i2s_sck,
    output logic                i2s_ws,
    output logic                i2s_sd,
    output logic                frame_start,
    output logic                underrun
);
    if (SLOT_BITS < DATA_SIZE + 1) begin : g_bad_slot
        $error("transmitter_i2s: SLOT_BITS must be at least DATA_SIZE+1");
    end

    localparam int unsigned BW = $clog2(2 * SLOT_BITS);
    localparam logic [BW-1:0] B_LAST    = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] SLOT_LEN  = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_SIZE);

    logic                 shift_c;
    logic                 unused_sck_rise;

    logic [DATA_SIZE-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [DATA_SIZE-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic                 buf_full_q, buf_full_d;
    logic [BW-1:0]        b_q, b_d;
    logic                 ws_q, ws_d, sd_q, sd_d;
    logic                 ready_q, ready_d;
    logic                 fs_q, fs_d, ur_q, ur_d;

    logic                 accept_c;
    i2s_ch_e              ch_c;
    logic [BW-1:0]        k_c;

    i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk        (clk),
        .rst        (rst),
        .sck_o      (i2s_sck),
        .sck_rise_c (unused_sck_rise),
        .sck_fall_c (shift_c)
    );

    // Load sees the pre-clk buffer, so an accept coinciding with an empty-buffer
    // frame start is kept for the following frame.
    always_comb begin
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        buf_full_d = buf_full_q;
        sh_l_d     = sh_l_q;
        sh_r_d     = sh_r_q;
        b_d        = b_q;
        ws_d       = ws_q;
        sd_d       = sd_q;
        fs_d       = 1'b0;
        ur_d       = 1'b0;

        accept_c = s_if.sample_valid && !buf_full_q;
        ch_c     = (b_q >= SLOT_LEN) ? CH_RIGHT : CH_LEFT;
        k_c      = (ch_c == CH_RIGHT) ? b_q - SLOT_LEN : b_q;

        if (accept_c) begin
            buf_l_d    = s_if.sample_left;
            buf_r_d    = s_if.sample_right;
            buf_full_d = 1'b1;
        end

        if (shift_c) begin
            b_d  = (b_q == B_LAST) ? '0 : b_q + BW'(1);
            ws_d = (ch_c == CH_RIGHT);
            sd_d = 1'b0;

            if (b_q == '0) begin
                if (buf_full_q) begin
                    sh_l_d     = buf_l_q;
                    sh_r_d     = buf_r_q;
                    buf_full_d = 1'b0;
                    fs_d       = 1'b1;
                end else begin
                    sh_l_d = '0;
                    sh_r_d = '0;
                    ur_d   = 1'b1;
                end
            end else if (k_c != '0 && k_c <= DATA_LAST) begin
                if (ch_c == CH_RIGHT) begin
                    sd_d   = sh_r_q[DATA_SIZE-1];
                    sh_r_d = sh_r_q << 1;
                end else begin
                    sd_d   = sh_l_q[DATA_SIZE-1];
                    sh_l_d = sh_l_q << 1;
                end
            end
        end

        ready_d = !buf_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            buf_full_q <= 1'b0;
            sh_l_q     <= '0;
            sh_r_q     <= '0;
            b_q        <= '0;
            ws_q       <= 1'b0;
            sd_q       <= 1'b0;
            ready_q    <= 1'b1;
            fs_q       <= 1'b0;
            ur_q       <= 1'b0;
        end else begin
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            buf_full_q <= buf_full_d;
            sh_l_q     <= sh_l_d;
            sh_r_q     <= sh_r_d;
            b_q        <= b_d;
            ws_q       <= ws_d;
            sd_q       <= sd_d;
            ready_q    <= ready_d;
            fs_q       <= fs_d;
            ur_q       <= ur_d;
        end
    end

    assign s_if.sample_ready = ready_q;
    assign i2s_ws            = ws_q;
    assign i2s_sd            = sd_q;
    assign frame_start       = fs_q;
    assign underrun          = ur_q;
endmodule

// File: tb/tb_transmitter_i2s.sv
// Scoreboard bench for transmitter_i2s (DATA_SIZE=24, SLOT_BITS=32, CLK_DIV=2).
module tb_transmitter_i2s;
    import i2s_pkg::*;

    typedef struct {
        int          n;
        i2s_stereo_t p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck, ws, sd, fs, ur;

    transmitter_i2s_if #(.DATA_SIZE(24)) bus ();

    transmitter_i2s #(.DATA_SIZE(24), .SLOT_BITS(32), .CLK_DIV(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_if        (bus),
        .i2s_sck     (sck),
        .i2s_ws      (ws),
        .i2s_sd      (sd),
        .frame_start (fs),
        .underrun    (ur)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int stray   = 0;
    exp_t sb[$];

    // Clk edges since reset release; frame n loads at edge 4+256n.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: pulses at load cycles, bits sampled on each SCK rise.
    i2s_stereo_t frm_exp;
    logic [23:0] acc_l, acc_r;
    int          ws_err, pad_err;

    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            if (cyc >= 4 && (cyc - 4) % 256 == 0) begin
                int  n;
                logic has;
                n   = (cyc - 4) / 256;
                has = (sb.size() > 0) && (sb[0].n == n);
                if (has) frm_exp = sb.pop_front().p;
                else     frm_exp = '0;
                check("frame_start", 32'(fs), 32'(has));
                check("underrun", 32'(ur), 32'(!has));
            end else if (fs || ur) begin
                stray++;
            end

            if (cyc >= 6 && (cyc - 6) % 4 == 0) begin
                int b, k;
                b = ((cyc - 6) / 4) % 64;
                k = b % 32;
                if (b == 0) begin
                    acc_l = '0; acc_r = '0; ws_err = 0; pad_err = 0;
                end
                if (sck !== 1'b1) ws_err++;
                if (ws !== ((b >= 32) ? 1'b1 : 1'b0)) ws_err++;
                if (k >= 1 && k <= 24) begin
                    if (b < 32) acc_l = {acc_l[22:0], sd};
                    else        acc_r = {acc_r[22:0], sd};
                end else if (sd !== 1'b0) begin
                    pad_err++;
                end
                if (b == 63) begin
                    check("left_word", 32'(acc_l), 32'(frm_exp.left));
                    check("right_word", 32'(acc_r), 32'(frm_exp.right));
                    check("pad_zero_errs", 32'(pad_err), 32'd0);
                    check("ws_sck_errs", 32'(ws_err), 32'd0);
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic send(input logic [23:0] l, input logic [23:0] r);
        int   guard;
        int   e;
        exp_t t;
        guard = 0;
        @(negedge clk);
        bus.sample_left  = l;
        bus.sample_right = r;
        bus.sample_valid = 1'b1;
        while (!bus.sample_ready && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 600) begin
            check("send_timeout", 32'd1, 32'd0);
            return;
        end
        e = cyc + 1;
        t.n = (e < 4) ? 0 : (e - 4) / 256 + 1;
        t.p.left  = l;
        t.p.right = r;
        sb.push_back(t);
        @(posedge clk);
        #1;
        check("ready_low_after_accept", 32'(bus.sample_ready), 32'd0);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sck"}, 32'(sck), 32'd0);
        check({tag, "_ws"}, 32'(ws), 32'd0);
        check({tag, "_sd"}, 32'(sd), 32'd0);
        check({tag, "_ready"}, 32'(bus.sample_ready), 32'd1);
        check({tag, "_fs"}, 32'(fs), 32'd0);
        check({tag, "_ur"}, 32'(ur), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.sample_left  = '0;
        bus.sample_right = '0;
        bus.sample_valid = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;

        wait_cyc(3);
        check("sck_high_cyc3", 32'(sck), 32'd1);
        wait_cyc(4);
        check("sck_first_fall", 32'(sck), 32'd0);
        check("ws_first_fall", 32'(ws), 32'd0);
        check("sd_first_fall", 32'(sd), 32'd0);

        wait_cyc(5);
        send(24'hA5A5A5, 24'h5A5A5A);
        idle();
        send(24'h800000, 24'h000001);
        for (int i = 0; i < 4; i++)
            send(24'h000100 + 24'(i), 24'h100000 + 24'(i));
        idle();

        wait_cyc(1541);
        check("ready_after_last_frame_start", 32'(bus.sample_ready), 32'd1);

        wait_cyc(2310);
        send(24'h123456, 24'h654321);
        idle();
        send(24'hDEAD00, 24'h00BEEF);
        idle();

        wait_cyc(164 + 256 * 10);
        check("sb_depth_before_reset", 32'(sb.size()), 32'd1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check_reset_vals("midframe_rst");
        @(negedge clk);
        rst = 1'b0;

        wait_cyc(772);
        check("stray_pulses", 32'(stray), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/transmitter_i2s.md
Name: transmitter_i2s

Overview:
- I2S master transmitter; the playback-side counterpart of the microphone receiver.
- Generates bit clock (i2s_sck), word select (i2s_ws) and serial data (i2s_sd) for an external DAC/amplifier from the system clock.
- Accepts stereo sample pairs over a valid/ready handshake into a one-pair holding buffer; serialises MSB-first with the standard I2S one-bit delay.
- Sends silence and flags underrun when no pair is available at frame start.

Parameters:
- DATA_SIZE, 24, sample width per channel in bits.
- SLOT_BITS, 32, SCK periods per channel slot; elaboration error if SLOT_BITS < DATA_SIZE+1.
- CLK_DIV, 4, clk cycles per SCK half-period; elaboration error if < 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- sample_left  input  DATA_SIZE  left-channel sample, two's complement
- sample_right  input  DATA_SIZE  right-channel sample
- sample_valid  input  1  pair presented
- sample_ready  output  1  holding buffer empty, pair accepted on valid&&ready
- i2s_sck  output  1  bit clock
- i2s_ws  output  1  word select, 0 = left, 1 = right
- i2s_sd  output  1  serial data, MSB first
- frame_start  output  1  one-clk pulse when a buffered pair is loaded
- underrun  output  1  one-clk pulse when a frame starts with the buffer empty

Behaviour:
- Clock and reset:
  - Single clock domain.
  - All outputs registered.
  - Reset is synchronous and active-high.
- Reset values:
  - i2s_sck=0, i2s_ws=0, i2s_sd=0, sample_ready=1, frame_start=0, underrun=0.
  - Buffer empty; shift registers, divider and bit index cleared.
  - Reset mid-frame aborts the frame and discards any buffered pair.
- SCK generation:
  - Divider counts 0..CLK_DIV-1; at terminal count it wraps and toggles i2s_sck.
  - A 1->0 toggle is a "shift event"; external device samples on SCK rising.
  - SCK period = 2*CLK_DIV clk cycles.
  - First shift event occurs at clk cycle 2*CLK_DIV after reset release.
- Bit index:
  - b counts 0..2*SLOT_BITS-1, advancing once per shift event and wrapping.
  - Width is $clog2(2*SLOT_BITS).
  - Slot-local k = b mod SLOT_BITS.
- Driven on each shift event, for bit b:
  - i2s_ws = 0 for b < SLOT_BITS, else 1; the WS edge coincides with k=0.
  - i2s_sd = 0 at k=0 (one-bit delay).
  - i2s_sd = bit DATA_SIZE-k of the current channel for k in 1..DATA_SIZE.
  - i2s_sd = 0 for k > DATA_SIZE.
  - ws and sd update in the same clk as the SCK falling edge.
- Frame load at the shift event with b=0:
  - Buffer full: both channels copy into shift registers; buffer clears; frame_start=1 for one clk.
  - Buffer empty: shift registers load zeros; underrun=1 for one clk.
- Handshake:
  - sample_ready = !buffer_full.
  - A pair is accepted on the rising clk with valid&&ready; accepted data must stay unchanged in the buffer until loaded.
  - Frame load and accept in the same clk: the load sees the pre-clk buffer state. If the buffer was empty, underrun fires and the accepted pair is kept for the next frame.
  - A full buffer keeps ready low; ready rises in the clk after frame_start.
- Latency:
  - A pair accepted into an empty buffer is loaded at the next b=0.
  - Its left MSB appears on i2s_sd one SCK period after the frame's WS falling edge.
- Throughput: one pair per 2*SLOT_BITS SCK periods.

Decomposition:
- Package i2s_pkg:
  - I2S_DATA_SIZE and I2S_SLOT_BITS defaults.
  - Channel enum CH_LEFT=0 / CH_RIGHT=1 (shared with the receiver).
  - Stereo sample struct {left, right}.
- Sub-module i2s_clk_div:
  - Produces i2s_sck plus one-clk sck_rise and sck_fall strobes from CLK_DIV.
  - Reusable if the receiver later generates its own SCK.

Test Plan (DATA_SIZE=24, SLOT_BITS=32, CLK_DIV=2, SCK period 4 clk, frame 256 clk):
- Hold rst=1 for 3 clk, release -> all outputs at reset values; first SCK fall at clk 4; ws=0, sd=0; underrun pulses at first b=0.
- Offer left=24'hA5A5A5, right=24'h5A5A5A before a frame -> one frame_start. Bits sampled on SCK rise: left slot k=1..24 = A5A5A5; right slot k=1..24 = 5A5A5A; zeros elsewhere; ws toggles every 32 SCK.
- Offer left=24'h800000, right=24'h000001 -> left MSB is the only 1 in the left slot (k=1); right has a 1 only at k=24; k=0 and k=25..31 are 0 in both slots.
- Keep sample_valid high with an incrementing counter -> ready low after each accept and high one clk after each frame_start; no underrun; one pair consumed per 256 clk, in order.
- Stop supplying data -> each subsequent frame gives an underrun pulse with sd=0 throughout; sck and ws keep running.
- Assert rst at b=40 with the buffer full -> next clk all outputs at reset values and ready=1. The discarded pair is never transmitted; the first frame after release underruns.
